// File: rtl/pipe_mult_approx_if.sv
// Operand and result streams of pipe_mult_approx, each with valid/ready handshake.
interface pipe_mult_approx_if #(parameter int W = 8);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_approx;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_y;
  logic           out_approx;

  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_y, out_approx
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_y, out_approx
  );
endinterface

// File: rtl/pipe_mult_approx.sv
// 3-stage unsigned multiplier, exact or approximate (AL*BL dropped); 3-cycle latency, 1 beat/cycle.
// Stalls hold data in place; bubbles collapse and in_ready drops only when all three stages are full.
module pipe_mult_approx #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_mult_approx_if.slave io,
  output logic [2:0]       stage_en,
  output logic [CNT_W-1:0] op_count
);
  localparam int H = W / 2;

  logic           v1, v2, v3;
  logic           ld1, ld2, ld3;
  logic [W-1:0]   a1, b1;
  logic           m1;
  logic [W-1:0]   p0, p1, p2, p3;
  logic           m2;
  logic [2*W-1:0] y3;
  logic           m3;

  logic [W-1:0]   p0_d, p1_d, p2_d, p3_d;
  logic [2*W-1:0] sum;

  assign ld3         = v2 & (~v3 | io.out_ready);
  assign ld2         = v1 & (~v2 | ld3);
  assign io.in_ready = ~v1 | ld2;
  assign ld1         = io.in_valid & io.in_ready;
  assign stage_en    = {ld3, ld2, ld1};

  assign io.out_valid  = v3;
  assign io.out_y      = y3;
  assign io.out_approx = m3;

  // Half-width parts are zero-extended so each partial product is a full W-bit result.
  always_comb begin
    p0_d = '0;
    if (!m1)
      p0_d = {{H{1'b0}}, a1[H-1:0]} * {{H{1'b0}}, b1[H-1:0]};
    p1_d = {{H{1'b0}}, a1[W-1:H]} * {{H{1'b0}}, b1[H-1:0]};
    p2_d = {{H{1'b0}}, a1[H-1:0]} * {{H{1'b0}}, b1[W-1:H]};
    p3_d = {{H{1'b0}}, a1[W-1:H]} * {{H{1'b0}}, b1[W-1:H]};
  end

  assign sum = {{W{1'b0}}, p0}
             + ({{W{1'b0}}, p1} << H)
             + ({{W{1'b0}}, p2} << H)
             + ({{W{1'b0}}, p3} << W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      y3       <= '0;
      m3       <= 1'b0;
      op_count <= '0;
    end else begin
      v1 <= ld1 | (v1 & ~ld2);
      v2 <= ld2 | (v2 & ~ld3);
      v3 <= ld3 | (v3 & ~io.out_ready);
      if (v3 && io.out_ready)
        op_count <= op_count + CNT_W'(1);
      if (ld3) begin
        y3 <= sum;
        m3 <= m2;
      end
    end
  end

  // Operand and partial-product registers only move on their load enable.
  always_ff @(posedge clk) begin
    if (ld1) begin
      a1 <= io.in_a;
      b1 <= io.in_b;
      m1 <= io.in_approx;
    end
    if (ld2) begin
      p0 <= p0_d;
      p1 <= p1_d;
      p2 <= p2_d;
      p3 <= p3_d;
      m2 <= m1;
    end
  end
endmodule

// File: tb/tb_pipe_mult_approx.sv
// Directed and randomised checks of pipe_mult_approx at W=8, with an 8-bit op_count so wrap is reachable.
module tb_pipe_mult_approx;
  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [2:0]       stage_en;
  logic [CNT_W-1:0] op_count;
  int               checks;
  int               errors;

  pipe_mult_approx_if #(.W(W)) bus ();

  pipe_mult_approx #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus),
    .stage_en (stage_en),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one beat, then waits (bounded) for its result; lat counts edges from the accepting one.
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic m,
                          output logic [15:0] y, output logic ap, output int lat);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_approx = m;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    y  = bus.out_y;
    ap = bus.out_approx;
    if (!bus.out_valid) lat = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_y !== 16'h0000) begin errors++; $display("FAIL reset_out_y got %h want 0000", bus.out_y); end
    checks++; if (bus.out_approx !== 1'b0) begin errors++; $display("FAIL reset_out_approx got %b want 0", bus.out_approx); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    checks++; if (stage_en !== 3'b000) begin errors++; $display("FAIL reset_stage_en got %b want 000", stage_en); end
  endtask

  task automatic test_exact();
    logic [7:0]  va [4] = '{8'hFF, 8'h13, 8'h80, 8'h00};
    logic [7:0]  vb [4] = '{8'hFF, 8'h21, 8'h02, 8'hFF};
    logic [15:0] ve [4] = '{16'hFE01, 16'd627, 16'd256, 16'd0};
    logic [15:0] y;
    logic        ap;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      send_one(va[i], vb[i], 1'b0, y, ap, lat);
      checks++; if (y !== ve[i]) begin errors++; $display("FAIL exact_y[%0d] got %0d want %0d", i, y, ve[i]); end
      checks++; if (ap !== 1'b0) begin errors++; $display("FAIL exact_mode[%0d] got %b want 0", i, ap); end
      checks++; if (lat != 3) begin errors++; $display("FAIL exact_latency[%0d] got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_approx();
    logic [7:0]  va [3] = '{8'hFF, 8'h13, 8'h0F};
    logic [7:0]  vb [3] = '{8'hFF, 8'h21, 8'h0F};
    logic [15:0] ve [3] = '{16'd64800, 16'd624, 16'd0};
    logic [15:0] y;
    logic        ap;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      send_one(va[i], vb[i], 1'b1, y, ap, lat);
      checks++; if (y !== ve[i]) begin errors++; $display("FAIL approx_y[%0d] got %0d want %0d", i, y, ve[i]); end
      checks++; if (ap !== 1'b1) begin errors++; $display("FAIL approx_mode[%0d] got %b want 1", i, ap); end
      checks++; if (lat != 3) begin errors++; $display("FAIL approx_latency[%0d] got %0d want 3", i, lat); end
    end
  endtask

  // Streams a = b = i (mod 256) for n beats with the sink always ready.
  task automatic test_stream(input int n);
    int          sent, got, cyc, first_cyc, last_cyc;
    logic [7:0]  av;
    logic [15:0] e;
    logic [7:0]  ecnt;
    do_reset();
    sent = 0; got = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    bus.out_ready = 1'b1;
    bus.in_approx = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    while (got < n && cyc < n + 20) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        av = got[7:0];
        e  = 16'(av) * 16'(av);
        checks++; if (bus.out_y !== e) begin errors++; $display("FAIL stream_y[%0d] got %0d want %0d", got, bus.out_y, e); end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
      bus.in_valid = (sent < n);
      bus.in_a     = sent[7:0];
      bus.in_b     = sent[7:0];
      cyc++;
    end
    bus.in_valid = 1'b0;
    ecnt = n[7:0];
    checks++; if (got != n) begin errors++; $display("FAIL stream_count got %0d want %0d", got, n); end
    checks++; if (last_cyc - first_cyc != n - 1) begin errors++; $display("FAIL stream_back_to_back span %0d want %0d", last_cyc - first_cyc, n - 1); end
    checks++; if (op_count !== ecnt) begin errors++; $display("FAIL stream_op_count got %0d want %0d", op_count, ecnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  va [5] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11};
    logic [7:0]  vb [5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    logic        vm [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ve [5] = '{16'd30, 16'd80, 16'd210, 16'd288, 16'd550};
    logic [15:0] held;
    logic        held_set, unstable;
    int          sent, got;
    sent = 0; got = 0; held = '0; held_set = 1'b0; unstable = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = va[0];
    bus.in_b      = vb[0];
    bus.in_approx = vm[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 9) begin
        checks++; if (sent != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", sent); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_y !== ve[0]) begin errors++; $display("FAIL bp_held_y got %0d want %0d", bus.out_y, ve[0]); end
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (held_set && bus.out_y !== held) unstable = 1'b1;
        held     = bus.out_y;
        held_set = 1'b1;
      end
      if (bus.out_valid && bus.out_ready && got < 5) begin
        checks++; if (bus.out_y !== ve[got]) begin errors++; $display("FAIL bp_y[%0d] got %0d want %0d", got, bus.out_y, ve[got]); end
        checks++; if (bus.out_approx !== vm[got]) begin errors++; $display("FAIL bp_mode[%0d] got %b want %b", got, bus.out_approx, vm[got]); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
      bus.out_ready = (cyc >= 9);
      bus.in_valid  = (sent < 5);
      if (sent < 5) begin
        bus.in_a      = va[sent];
        bus.in_b      = vb[sent];
        bus.in_approx = vm[sent];
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (unstable) begin errors++; $display("FAIL bp_stable got changing want stable"); end
    checks++; if (got != 5) begin errors++; $display("FAIL bp_results got %0d want 5", got); end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    seen = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_approx = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd1;
    bus.in_b      = 8'd2;
    @(posedge clk);
    #1 bus.in_a = 8'd3;
    bus.in_b = 8'd4;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_out_valid got 1 want never"); end
    checks++; if (bus.out_y !== 16'h0000) begin errors++; $display("FAIL midreset_out_y got %h want 0000", bus.out_y); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL midreset_op_count got %0d want 0", op_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_random();
    logic [16:0] q[$];
    logic [16:0] exp_v;
    logic [15:0] e;
    do_reset();
    for (int cyc = 0; cyc < 2030; cyc++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = (cyc < 2000) && ($urandom_range(3) != 0);
      bus.out_ready = (cyc >= 2000) || ($urandom_range(2) != 0);
      bus.in_a      = 8'($urandom);
      bus.in_b      = 8'($urandom);
      bus.in_approx = 1'($urandom);
      @(negedge clk);
      if (q.size() == 0 && !bus.in_valid) begin
        checks++; if (stage_en !== 3'b000) begin errors++; $display("FAIL rand_idle_stage_en got %b want 000", stage_en); end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious got y=%0d want no result", bus.out_y);
        end else begin
          exp_v = q.pop_front();
          checks++; if ({bus.out_approx, bus.out_y} !== exp_v) begin
            errors++; $display("FAIL rand_result got %b/%0d want %b/%0d", bus.out_approx, bus.out_y, exp_v[16], exp_v[15:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = 16'(bus.in_a) * 16'(bus.in_b);
        if (bus.in_approx) e = e - 16'(bus.in_a[3:0]) * 16'(bus.in_b[3:0]);
        q.push_back({bus.in_approx, e});
      end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_exact();
    test_approx();
    test_stream(100);
    test_backpressure();
    test_reset_midflight();
    test_stream(260);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
